// File: rtl/poly_buzzer_mixer.sv
// rtl/poly_buzzer_mixer.sv - multi-voice square-wave tone generator with saturating stereo mixer
module poly_buzzer_mixer #(
  parameter int          NUM_CH   = 2,
  parameter int          DIV_W    = 20,
  parameter int          VOL_W    = 4,
  parameter logic [15:0] AMP_STEP = 16'h0800
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*DIV_W-1:0]   note_div,
  input  logic [NUM_CH*VOL_W-1:0]   ch_vol,
  input  logic [NUM_CH*2-1:0]       ch_pan,
  output logic [NUM_CH-1:0]         ch_phase,
  output logic [15:0]               au_left,
  output logic [15:0]               au_right
);

  // Mix width: one extra bit per doubling of voices plus one so sums never wrap.
  localparam int SUM_W = 16 + $clog2(NUM_CH) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32768);

  logic [DIV_W-1:0]        cnt     [NUM_CH];
  logic [DIV_W-1:0]        div_act [NUM_CH];
  logic [NUM_CH-1:0]       phase;

  logic [VOL_W-1:0]        vol;
  logic [1:0]              pan;
  logic [15:0]             amp;
  logic signed [SUM_W-1:0] amp_ext;
  logic signed [SUM_W-1:0] contrib;
  logic signed [SUM_W-1:0] sum_l;
  logic signed [SUM_W-1:0] sum_r;

  function automatic logic [15:0] sat16(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)
      return 16'h7FFF;
    else if (v < SAT_MIN)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  // Per-voice divider: a new note_div is only taken on the load cycle or at a half-period boundary.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || !ch_en[i]) begin
        cnt[i]     <= '0;
        div_act[i] <= '0;
        phase[i]   <= 1'b0;
      end else if (div_act[i] == '0) begin
        div_act[i] <= note_div[i*DIV_W +: DIV_W];
        cnt[i]     <= '0;
      end else if (cnt[i] == div_act[i]) begin
        cnt[i]     <= '0;
        phase[i]   <= ~phase[i];
        div_act[i] <= note_div[i*DIV_W +: DIV_W];
      end else begin
        cnt[i]     <= cnt[i] + 1'b1;
      end
    end
  end

  // Voice contributions and stereo sums; a disabled voice is silenced through div_act,
  // so dropping ch_en reaches the output two cycles later.
  always_comb begin
    sum_l   = '0;
    sum_r   = '0;
    vol     = '0;
    pan     = '0;
    amp     = '0;
    amp_ext = '0;
    contrib = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      vol     = ch_vol[i*VOL_W +: VOL_W];
      pan     = ch_pan[2*i +: 2];
      amp     = {{(16-VOL_W){1'b0}}, vol} * AMP_STEP;
      amp_ext = {{(SUM_W-16){amp[15]}}, amp};
      if (div_act[i] == '0 || vol == '0 || pan == 2'b11)
        contrib = '0;
      else if (phase[i])
        contrib = amp_ext;
      else
        contrib = -amp_ext;
      if (pan == 2'b00 || pan == 2'b01)
        sum_l = sum_l + contrib;
      if (pan == 2'b00 || pan == 2'b10)
        sum_r = sum_r + contrib;
    end
  end

  // Registered, saturated output samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      au_left  <= 16'h0000;
      au_right <= 16'h0000;
    end else begin
      au_left  <= sat16(sum_l);
      au_right <= sat16(sum_r);
    end
  end

  assign ch_phase = phase;

endmodule

// File: tb/tb_poly_buzzer_mixer.sv
// tb/tb_poly_buzzer_mixer.sv - directed self-checking bench for poly_buzzer_mixer
module tb_poly_buzzer_mixer;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 20;
  localparam int VOL_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*DIV_W-1:0] note_div;
  logic [NUM_CH*VOL_W-1:0] ch_vol;
  logic [NUM_CH*2-1:0]     ch_pan;
  logic [NUM_CH-1:0]       ch_phase;
  logic [15:0]             au_left;
  logic [15:0]             au_right;

  int n_cmp = 0;
  int n_err = 0;

  poly_buzzer_mixer #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .VOL_W(VOL_W), .AMP_STEP(16'h0800)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .note_div(note_div), .ch_vol(ch_vol),
    .ch_pan(ch_pan), .ch_phase(ch_phase), .au_left(au_left), .au_right(au_right)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ch_en = '0; note_div = '0; ch_vol = '0; ch_pan = '0;
    do_reset();
    n_cmp++; if (ch_phase !== 2'b00) begin n_err++; $display("FAIL reset_phase got %b expected 00", ch_phase); end
    n_cmp++; if (au_left !== 16'h0000) begin n_err++; $display("FAIL reset_left got %h expected 0000", au_left); end
    n_cmp++; if (au_right !== 16'h0000) begin n_err++; $display("FAIL reset_right got %h expected 0000", au_right); end
  endtask

  task automatic test_single_voice();
    logic [15:0] exp_au;
    logic        exp_ph;
    ch_en = 2'b01; note_div = '0; note_div[0 +: DIV_W] = 20'd3;
    ch_vol = '0; ch_vol[0 +: VOL_W] = 4'd15; ch_pan = 4'b0000;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      step(1);
      exp_ph = 1'(((k - 1) / 4) % 2);
      if (k == 1) exp_au = 16'h0000;
      else exp_au = (((k - 2) / 4) % 2 == 1) ? 16'h7800 : 16'h8800;
      n_cmp++; if (ch_phase[0] !== exp_ph) begin n_err++; $display("FAIL single_phase k=%0d got %b expected %b", k, ch_phase[0], exp_ph); end
      n_cmp++; if (au_left !== exp_au) begin n_err++; $display("FAIL single_left k=%0d got %h expected %h", k, au_left, exp_au); end
      n_cmp++; if (au_right !== exp_au) begin n_err++; $display("FAIL single_right k=%0d got %h expected %h", k, au_right, exp_au); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_au;
    logic [1:0]  exp_ph;
    ch_en = 2'b11; note_div = {20'd3, 20'd3}; ch_vol = {4'd15, 4'd15}; ch_pan = 4'b0000;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(1);
      exp_ph = (((k - 1) / 4) % 2 == 1) ? 2'b11 : 2'b00;
      n_cmp++; if (ch_phase !== exp_ph) begin n_err++; $display("FAIL sat_phase k=%0d got %b expected %b", k, ch_phase, exp_ph); end
      if (k >= 2) begin
        exp_au = (k >= 6) ? 16'h7FFF : 16'h8000;
        n_cmp++; if (au_left !== exp_au) begin n_err++; $display("FAIL sat_left k=%0d got %h expected %h", k, au_left, exp_au); end
        n_cmp++; if (au_right !== exp_au) begin n_err++; $display("FAIL sat_right k=%0d got %h expected %h", k, au_right, exp_au); end
      end
    end
  endtask

  task automatic test_note_change();
    logic exp_ph;
    ch_en = 2'b01; note_div = '0; note_div[0 +: DIV_W] = 20'd9;
    ch_vol = '0; ch_vol[0 +: VOL_W] = 4'd15; ch_pan = 4'b0000;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(1);
      if (k < 11) exp_ph = 1'b0;
      else if (k < 14) exp_ph = 1'b1;
      else if (k < 17) exp_ph = 1'b0;
      else exp_ph = 1'b1;
      n_cmp++; if (ch_phase[0] !== exp_ph) begin n_err++; $display("FAIL notechg_phase k=%0d got %b expected %b", k, ch_phase[0], exp_ph); end
      if (k == 5) note_div[0 +: DIV_W] = 20'd2;
    end
  endtask

  task automatic test_pan();
    logic [15:0] exp_l, exp_r;
    ch_en = 2'b11; note_div = {20'd3, 20'd3}; ch_vol = {4'd4, 4'd8}; ch_pan = {2'b10, 2'b01};
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k >= 2) begin
        if (k >= 6 && k <= 9) begin exp_l = 16'h4000; exp_r = 16'h2000; end
        else begin exp_l = 16'hC000; exp_r = 16'hE000; end
        if (k == 10) exp_l = 16'h0000;
        n_cmp++; if (au_left !== exp_l) begin n_err++; $display("FAIL pan_left k=%0d got %h expected %h", k, au_left, exp_l); end
        n_cmp++; if (au_right !== exp_r) begin n_err++; $display("FAIL pan_right k=%0d got %h expected %h", k, au_right, exp_r); end
      end
      if (k == 9) ch_pan[1:0] = 2'b11;
    end
  endtask

  task automatic test_silent();
    logic exp_ph;
    ch_en = 2'b01; note_div = '0; ch_vol = '0; ch_vol[0 +: VOL_W] = 4'd15; ch_pan = 4'b0000;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1);
      n_cmp++; if (ch_phase !== 2'b00) begin n_err++; $display("FAIL div0_phase k=%0d got %b expected 00", k, ch_phase); end
      n_cmp++; if (au_left !== 16'h0000 || au_right !== 16'h0000) begin n_err++; $display("FAIL div0_au k=%0d got %h/%h expected 0000/0000", k, au_left, au_right); end
    end
    note_div[0 +: DIV_W] = 20'd5; ch_vol = '0;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      step(1);
      exp_ph = (k >= 7 && k <= 12);
      n_cmp++; if (ch_phase[0] !== exp_ph) begin n_err++; $display("FAIL vol0_phase k=%0d got %b expected %b", k, ch_phase[0], exp_ph); end
      n_cmp++; if (au_left !== 16'h0000 || au_right !== 16'h0000) begin n_err++; $display("FAIL vol0_au k=%0d got %h/%h expected 0000/0000", k, au_left, au_right); end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_ph;
    ch_en = 2'b01; note_div = '0; note_div[0 +: DIV_W] = 20'd3;
    ch_vol = '0; ch_vol[0 +: VOL_W] = 4'd15; ch_pan = 4'b0000;
    do_reset();
    step(6);
    n_cmp++; if (ch_phase[0] !== 1'b1) begin n_err++; $display("FAIL midrst_pre got %b expected 1", ch_phase[0]); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (ch_phase !== 2'b00) begin n_err++; $display("FAIL midrst_phase got %b expected 00", ch_phase); end
    n_cmp++; if (au_left !== 16'h0000 || au_right !== 16'h0000) begin n_err++; $display("FAIL midrst_au got %h/%h expected 0000/0000", au_left, au_right); end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      exp_ph = (k == 5);
      n_cmp++; if (ch_phase[0] !== exp_ph) begin n_err++; $display("FAIL midrst_toggle k=%0d got %b expected %b", k, ch_phase[0], exp_ph); end
    end
  endtask

  initial begin
    rst = 1'b1; ch_en = '0; note_div = '0; ch_vol = '0; ch_pan = '0;
    test_reset();
    test_single_voice();
    test_saturation();
    test_note_change();
    test_pan();
    test_silent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
